// File: rtl/kmeans_stream_tx_if.sv
// rtl/kmeans_stream_tx_if.sv - loader write port and CORE-side stream bundle
interface kmeans_stream_tx_if;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_valid;

   modport master (
      output wr_en, wr_data, out_valid,
      input  wr_ready, in_valid, in_data
   );

   modport slave (
      input  wr_en, wr_data, out_valid,
      output wr_ready, in_valid, in_data
   );
endinterface

// File: rtl/kmeans_stream_tx.sv
// rtl/kmeans_stream_tx.sv - buffers samples and replays them to CORE as header+data frame
module kmeans_stream_tx #(
   parameter int DEPTH   = 64,
   parameter int AW      = 6,
   parameter int TIMEOUT = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   kmeans_stream_tx_if.slave   bus,
   input  logic                start,
   output logic                busy,
   output logic                frame_done,
   output logic                timeout,
   output logic [15:0]         res_cnt
);
   localparam logic [AW:0]  DEPTH_W = DEPTH[AW:0];
   localparam logic [31:0]  T_LAST  = TIMEOUT - 1;

   // FIN holds one cycle after the end pulse so busy falls the cycle after it
   typedef enum logic [2:0] {IDLE, HDR, DATA, WAIT, FIN} state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fill;
   logic [AW:0]   fill_next;
   logic          push;
   logic          seen;
   logic [31:0]   timer;

   assign bus.wr_ready = (state == IDLE) && (fill < DEPTH_W);
   assign push         = bus.wr_en && bus.wr_ready;
   assign fill_next    = fill + {{AW{1'b0}}, push};
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fill         <= '0;
         seen         <= 1'b0;
         timer        <= '0;
         res_cnt      <= '0;
         frame_done   <= 1'b0;
         timeout      <= 1'b0;
         bus.in_valid <= 1'b0;
         bus.in_data  <= '0;
      end else begin
         frame_done <= 1'b0;
         timeout    <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         case (state)
            IDLE: begin
               fill <= fill_next;
               if (start && fill_next != '0) begin
                  state        <= HDR;
                  bus.in_valid <= 1'b1;
                  bus.in_data  <= 16'(fill_next);
               end
            end
            // Frame length equals the fill, so draining the buffer ends the frame
            HDR, DATA: begin
               if (fill != '0) begin
                  state        <= DATA;
                  bus.in_valid <= 1'b1;
                  bus.in_data  <= mem[rd_ptr];
                  rd_ptr       <= rd_ptr + 1'b1;
                  fill         <= fill - 1'b1;
               end else begin
                  state        <= WAIT;
                  bus.in_valid <= 1'b0;
                  bus.in_data  <= '0;
                  res_cnt      <= '0;
                  seen         <= 1'b0;
                  timer        <= '0;
               end
            end
            WAIT: begin
               if (bus.out_valid) begin
                  seen <= 1'b1;
                  if (res_cnt != 16'hFFFF) res_cnt <= res_cnt + 16'd1;
               end
               if (!bus.out_valid && seen) begin
                  frame_done <= 1'b1;
                  state      <= FIN;
               end else if (timer == T_LAST) begin
                  timeout <= 1'b1;
                  state   <= FIN;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
